alu_seq: RTL and testbench

// Registered, parametrised ALU that replaces the combinational 8-bit ALU in the CPU datapath.
// - Adds logic, shift, add-with-carry and a multi-cycle shift-add multiply.
// - Uses a start/done handshake and keeps the carry and zero flags in registers.
// - Sits between the register file read ports and the writeback mux; the control FSM stalls on busy.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and default-size definitions for the sequential ALU.
package alu_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_OP_W  = 4;

  // Opcode values; addition..decrement keep their historical names.
  localparam int OP_ADDITION     = 0;
  localparam int OP_SUBSTRACTION = 1;
  localparam int OP_INCREMENT    = 2;
  localparam int OP_DECREMENT    = 3;
  localparam int OP_ADD_CARRY    = 4;
  localparam int OP_AND_OP       = 5;
  localparam int OP_OR_OP        = 6;
  localparam int OP_XOR_OP       = 7;
  localparam int OP_SHL          = 8;
  localparam int OP_SHR          = 9;
  localparam int OP_MUL          = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;

  // Upper half plus multiplicand when the current multiplier bit (product[0]) is set.
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) sum = sum + {1'b0, mcand};
  end

  // Product register holds {partial sum, remaining multiplier bits}; shift right each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (go && !busy) begin
        mcand   <= a;
        product <= {{WIDTH{1'b0}}, b};
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        product <= {sum, product[WIDTH-1:1]};
        cnt     <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, carry/zero flag registers and a
// multi-cycle multiplier. Results reach the outputs only on the done cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W  = DEF_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             flags_c_val,
  output logic             flags_z_val
);

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  state_e state, state_n;

  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;

  logic             accept, mul_go, start_mul;
  logic             mul_busy, mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]   ext_a, ext_b, tmp;
  logic             alu_c, alu_z;

  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_c, res_z;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .go      (mul_go),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state, handshake and multiplier kick-off; start is blocked on the done cycle.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    mul_go    = 1'b0;
    busy      = 1'b1;
    start_mul = (operation == OP_W'(OP_MUL));
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && !done) begin
          accept  = 1'b1;
          mul_go  = start_mul;
          state_n = start_mul ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: state_n = ST_DONE;
      ST_MUL:  if (mul_done && !mul_busy) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Latch operands, opcode and the carry-in seen at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else if (accept) begin
      op_q  <= operation;
      a_q   <= A;
      b_q   <= B;
      cin_q <= flags_c_val;
    end
  end

  // Single-cycle ops on a WIDTH+1 bit temporary; logic ops pass the carry through.
  always_comb begin
    ext_a = {1'b0, a_q};
    ext_b = {1'b0, b_q};
    tmp   = '0;
    alu_c = cin_q;
    case (op_q)
      OP_W'(OP_ADDITION):     begin tmp = ext_a + ext_b;               alu_c = tmp[WIDTH];  end
      OP_W'(OP_SUBSTRACTION): begin tmp = ext_a - ext_b;               alu_c = ~tmp[WIDTH]; end
      OP_W'(OP_INCREMENT):    begin tmp = ext_a + ONE;                 alu_c = tmp[WIDTH];  end
      OP_W'(OP_DECREMENT):    begin tmp = ext_a - ONE;                 alu_c = ~tmp[WIDTH]; end
      OP_W'(OP_ADD_CARRY):    begin tmp = ext_a + ext_b + {{WIDTH{1'b0}}, cin_q};
                                    alu_c = tmp[WIDTH]; end
      OP_W'(OP_AND_OP):       tmp = ext_a & ext_b;
      OP_W'(OP_OR_OP):        tmp = ext_a | ext_b;
      OP_W'(OP_XOR_OP):       tmp = ext_a ^ ext_b;
      OP_W'(OP_SHL):          begin tmp = {1'b0, a_q[WIDTH-2:0], 1'b0}; alu_c = a_q[WIDTH-1]; end
      OP_W'(OP_SHR):          begin tmp = {2'b00, a_q[WIDTH-1:1]};      alu_c = a_q[0];       end
      default:                begin tmp = '0;                          alu_c = 1'b0;        end
    endcase
    alu_z = (tmp[WIDTH-1:0] == '0);
  end

  // Stage the result: ALU result from EXEC, product when the multiplier finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_lo <= '0;
      res_hi <= '0;
      res_c  <= 1'b0;
      res_z  <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_lo <= tmp[WIDTH-1:0];
      res_hi <= '0;
      res_c  <= alu_c;
      res_z  <= alu_z;
    end else if (state == ST_MUL && mul_done) begin
      res_lo <= product[WIDTH-1:0];
      res_hi <= product[2*WIDTH-1:WIDTH];
      res_c  <= (product[2*WIDTH-1:WIDTH] != '0);
      res_z  <= (product == '0);
    end
  end

  // Visible outputs change only together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      C           <= '0;
      C_hi        <= '0;
      flags_c_val <= 1'b0;
      flags_z_val <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        C           <= res_lo;
        C_hi        <= res_hi;
        flags_c_val <= res_c;
        flags_z_val <= res_z;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table plus handshake corner cases.
module tb_alu_seq;

  localparam int W  = 8;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [OW-1:0] operation;
  logic [W-1:0]  A, B;
  logic          busy, done;
  logic [W-1:0]  C, C_hi;
  logic          flags_c_val, flags_z_val;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W), .OP_W(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .operation   (operation),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .C           (C),
    .C_hi        (C_hi),
    .flags_c_val (flags_c_val),
    .flags_z_val (flags_z_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic [7:0] c, hi;
    logic       cf, zf;
    int         lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait for idle, issue one op, scramble inputs after accept, run to done.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit hold_ok);
    logic [7:0] c0, h0;
    logic       f0, z0;
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    c0 = C; h0 = C_hi; f0 = flags_c_val; z0 = flags_z_val;
    operation = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operation = 4'($urandom); A = 8'($urandom); B = 8'($urandom);
    lat = 0;
    hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (C !== c0 || C_hi !== h0 || flags_c_val !== f0 || flags_z_val !== z0 || busy !== 1'b1)
        hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, ndone;
    bit hold_ok;
    logic [7:0] cap_c, cap_hi;

    vecs[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 2};  // add
    vecs[1]  = '{4'd4,  8'h01, 8'h01, 8'h03, 8'h00, 1'b0, 1'b0, 2};  // adc, cin=1
    vecs[2]  = '{4'd1,  8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 2};  // sub equal
    vecs[3]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b0, 2};  // sub borrow
    vecs[4]  = '{4'd3,  8'h00, 8'h33, 8'hFF, 8'h00, 1'b0, 1'b0, 2};  // dec 0
    vecs[5]  = '{4'd2,  8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2};  // inc wrap
    vecs[6]  = '{4'd5,  8'hF0, 8'h3C, 8'h30, 8'h00, 1'b1, 1'b0, 2};  // and, c kept
    vecs[7]  = '{4'd6,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2};  // or zero
    vecs[8]  = '{4'd10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 10}; // mul max
    vecs[9]  = '{4'd10, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 10}; // mul zero
    vecs[10] = '{4'd4,  8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 2};  // adc, cin=0
    vecs[11] = '{4'd8,  8'h81, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 2};  // shl
    vecs[12] = '{4'd7,  8'hAA, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b1, 2};  // xor, c kept
    vecs[13] = '{4'd13, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b1, 2};  // undefined
    vecs[14] = '{4'd9,  8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2};  // shr
    vecs[15] = '{4'd4,  8'h7F, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 2};  // adc wrap, cin=1
    vecs[16] = '{4'd10, 8'h12, 8'h34, 8'hA8, 8'h03, 1'b1, 1'b0, 10}; // mul 0x3A8
    vecs[17] = '{4'd11, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 2};  // undefined
    vecs[18] = '{4'd9,  8'h80, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 2};  // shr
    vecs[19] = '{4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 2};  // add

    rst = 1'b1; start = 1'b0; operation = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_C", 32'(C), 32'h0);
    chk("rst_C_hi", 32'(C_hi), 32'h0);
    chk("rst_c", 32'(flags_c_val), 32'h0);
    chk("rst_z", 32'(flags_z_val), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hold_ok);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
      chk($sformatf("v%0d_C", i), 32'(C), 32'(vecs[i].c));
      chk($sformatf("v%0d_C_hi", i), 32'(C_hi), 32'(vecs[i].hi));
      chk($sformatf("v%0d_c", i), 32'(flags_c_val), 32'(vecs[i].cf));
      chk($sformatf("v%0d_z", i), 32'(flags_z_val), 32'(vecs[i].zf));
      chk($sformatf("v%0d_hold", i), 32'(hold_ok), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), 32'(done), 32'h0);
    end

    // start held during a multiply is ignored: exactly one done, mul result.
    @(negedge clk);
    operation = 4'd10; A = 8'h03; B = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    operation = 4'd0; A = 8'h01; B = 8'h01;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; cap_c = '0; cap_hi = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        cap_c = C;
        cap_hi = C_hi;
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_C", 32'(cap_c), 32'h0F);
    chk("busy_start_C_hi", 32'(cap_hi), 32'h00);

    // start raised in the done cycle is ignored, accepted in the cycle after.
    run_op(4'd0, 8'h01, 8'h02, lat, hold_ok);
    chk("b2b_first_C", 32'(C), 32'h03);
    @(negedge clk);
    chk("b2b_done_cycle", 32'(done), 32'h1);
    operation = 4'd0; A = 8'h10; B = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ignored_in_done", 32'(busy), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", 32'(busy), 32'h1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat", 32'(lat), 32'd2);
    chk("b2b_C", 32'(C), 32'h30);

    // Reset in the middle of a multiply: outputs cleared, no done pulse later.
    @(negedge clk);
    @(negedge clk);
    operation = 4'd10; A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_C", 32'(C), 32'h0);
    chk("midrst_C_hi", 32'(C_hi), 32'h0);
    chk("midrst_c", 32'(flags_c_val), 32'h0);
    chk("midrst_z", 32'(flags_z_val), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
